uart_tx: RTL and testbench

- UART transmitter; the line-side counterpart of `uart_rx`. It uses the same parameters and line format, so a `uart_tx` → `uart_rx` loopback returns the input beat unchanged.
- Accepts a W_IN-bit beat on a valid/ready slave interface and splits it into NUM_WORDS = W_IN/BITS_PER_WORD words.
- Serialises each word as one frame on `tx`: start bit, data bits, stop bit.
- Sits between the processing datapath and the board UART pin.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 96 +++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Valid/ready beat interface feeding the UART transmitter.
interface uart_tx_if #(
    parameter int W_IN = 16
);
    logic            valid;
    logic            ready;
    logic [W_IN-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: splits a W_IN-bit beat into words and sends each as
// start / inverted data (LSB first) / stop frames on tx.
module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_IN             = 16
) (
    input  logic      clk,
    input  logic      rstn,
    uart_tx_if.slave  s,
    output logic      tx,
    output logic      busy
);
    localparam int NUM_WORDS   = W_IN / BITS_PER_WORD;
    localparam int PACKET_BITS = BITS_PER_WORD + 2;
    localparam int PW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (PACKET_BITS > 1) ? $clog2(PACKET_BITS) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(PACKET_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(PACKET_BITS - 2);
    localparam logic [WW-1:0] WORD_LAST  = WW'(NUM_WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [PW-1:0]   pulse_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [WW-1:0]   word_cnt;
    logic [W_IN-1:0] shreg;
    logic            ready;

    assign s.ready = ready;

    // Words are contiguous LSB-first, so one right shift per data bit walks the whole beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            tx        <= 1'b1;
            ready     <= 1'b0;
            busy      <= 1'b0;
            pulse_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                    if (s.valid && ready) begin
                        shreg     <= s.data;
                        state     <= SEND;
                        pulse_cnt <= '0;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        tx        <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        pulse_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (word_cnt == WORD_LAST) begin
                                word_cnt <= '0;
                                state    <= IDLE;
                                ready    <= 1'b1;
                                busy     <= 1'b0;
                                tx       <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + WW'(1);
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == DATA_LAST) begin
                                tx <= 1'b1;
                            end else begin
                                tx    <= ~shreg[0];
                                shreg <= shreg >> 1;
                            end
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed beats push expected values into a queue; a line
// decoder process reassembles beats from tx and compares them against the queue.
module tb_uart_tx;
    localparam int CPP = 4;
    localparam int BPW = 8;
    localparam int W   = 16;
    localparam int NW  = W / BPW;
    localparam int PB  = BPW + 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic tx;
    logic busy;

    uart_tx_if #(.W_IN(W)) s_if ();

    uart_tx #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .W_IN            (W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .s   (s_if),
        .tx  (tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cycle = 0;
    logic [W-1:0] exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Waits for s_ready, then presents one beat for exactly one handshake edge.
    task automatic applyStimulus(input logic [W-1:0] beat, input bit push, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        n = 0;
        @(negedge clk);
        while (s_if.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (s_if.ready !== 1'b1) begin
            timeoutFail("ready_wait");
            return;
        end
        s_if.valid = 1'b1;
        s_if.data  = beat;
        if (push) exp_q.push_back(beat);
        @(posedge clk);
        #1;
        hs_cycle   = cyc;
        s_if.valid = 1'b0;
        s_if.data  = W'($urandom);
    endtask

    // Cycle-exact line check right after a handshake; seq lists packet bits in time order, MSB first.
    task automatic checkLine(input logic [NW*PB-1:0] seq);
        for (int k = 0; k < NW * PB * CPP; k++) begin
            @(negedge clk);
            checkOutput("line_bit", 32'(tx), 32'(seq[NW*PB-1 - k/CPP]));
            if (k == NW * PB * CPP - 1) begin
                checkOutput("ready_last_cycle", 32'(s_if.ready), 32'd0);
                checkOutput("busy_last_cycle", 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        checkOutput("ready_after_beat", 32'(s_if.ready), 32'd1);
        checkOutput("busy_after_beat", 32'(busy), 32'd0);
        checkOutput("tx_idle_after_beat", 32'(tx), 32'd1);
    endtask

    // Reference receiver: samples mid-bit, checks framing, rebuilds beats and pops the scoreboard.
    initial begin : monitor
        bit            active;
        int            cnt;
        int            widx;
        int            idx;
        logic [BPW-1:0] wbits;
        logic [W-1:0]   acc;
        logic [W-1:0]   expv;
        active = 1'b0;
        cnt    = 0;
        widx   = 0;
        wbits  = '0;
        acc    = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                active = 1'b0;
                widx   = 0;
                acc    = '0;
            end else begin
                if (!active) begin
                    if (tx === 1'b0) begin
                        active = 1'b1;
                        cnt    = 0;
                    end
                end else begin
                    cnt++;
                end
                if (active && (cnt % CPP) == CPP / 2) begin
                    idx = cnt / CPP;
                    if (idx == 0) begin
                        checkOutput("start_bit", 32'(tx), 32'd0);
                    end else if (idx <= BPW) begin
                        wbits[idx-1] = ~tx;
                    end else begin
                        checkOutput("stop_bit", 32'(tx), 32'd1);
                        active = 1'b0;
                        acc[widx*BPW +: BPW] = wbits;
                        widx++;
                        if (widx == NW) begin
                            widx = 0;
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("[TB] FAIL unexpected_beat: got %0h, required none", acc);
                            end else begin
                                expv = exp_q.pop_front();
                                checkOutput("beat", 32'(acc), 32'(expv));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        int first_hs;
        int second_hs;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        rstn       = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_ready", 32'(s_if.ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", 32'(s_if.ready), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("idle_tx", 32'(tx), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] directed beats");
        applyStimulus(16'hA53C, 1'b1, 0);
        checkLine(20'b0110000111_0010110101);
        applyStimulus(16'h0000, 1'b1, 1);
        checkLine(20'b0111111111_0111111111);
        applyStimulus(16'hFFFF, 1'b1, 1);
        checkLine(20'b0000000001_0000000001);

        $display("[TB] random beats with gaps");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(W'($urandom), 1'b1, $urandom_range(1, 20));
        end

        $display("[TB] backpressure");
        n = 0;
        @(negedge clk);
        while (s_if.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        s_if.valid = 1'b1;
        s_if.data  = 16'h1357;
        exp_q.push_back(16'h1357);
        @(posedge clk);
        #1;
        first_hs  = cyc;
        second_hs = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (s_if.ready === 1'b1) begin
                s_if.data = 16'hC0DE;
                exp_q.push_back(16'hC0DE);
                @(posedge clk);
                #1;
                second_hs = cyc;
                break;
            end
            s_if.data = W'($urandom);
        end
        s_if.valid = 1'b0;
        if (second_hs < 0) timeoutFail("second_accept");
        else checkOutput("accept_spacing_ge_81", 32'(second_hs - first_hs >= 81), 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(16'h1240, 1'b0, 2);
        repeat (30) @(negedge clk);
        checkOutput("pre_reset_tx", 32'(tx), 32'd0);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_tx", 32'(tx), 32'd1);
        checkOutput("async_reset_ready", 32'(s_if.ready), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rerelease", 32'(s_if.ready), 32'd1);
        applyStimulus(16'h00FF, 1'b1, 0);
        checkLine(20'b0000000001_0111111111);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeoutFail("scoreboard_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
